// File: rtl/as5401_cpu.sv
// AS5401 4-bit accumulator core.
// One opcode runs per 4-clock machine cycle (T0..T3), and the current phase is exported one-hot.
// The opcode is latched at the end of T0, the operand at the end of T2.
// Architectural state commits at the end of T3.
module as5401_cpu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instr,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  input  logic       ef0,
  input  logic       ef1,
  output logic [7:0] db0,
  output logic [3:0] clock_state,
  output logic       write,
  output logic       i_f,
  output logic       mar,
  output logic       jmp
);

  typedef enum logic [3:0] {
    T0 = 4'b0001,
    T1 = 4'b0010,
    T2 = 4'b0100,
    T3 = 4'b1000
  } phase_t;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0, OP_STR  = 4'h1, OP_SEI = 4'h2, OP_LML = 4'h3,
    OP_JMP  = 4'h4, OP_SKF0 = 4'h5, OP_SKF1 = 4'h6, OP_LDR = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
    OP_XOR  = 4'hC, OP_NOT  = 4'hD, OP_NOP = 4'hE, OP_LMH = 4'hF
  } op_t;

  phase_t     phase, phase_nxt;
  op_t        op;
  logic [3:0] acc, r, opnd;
  logic       carry, skip;

  // Next-state values produced by the T3 commit
  logic [3:0] acc_nxt, r_nxt;
  logic [7:0] db0_nxt;
  logic       carry_nxt, i_f_nxt, skip_nxt;
  logic [4:0] sum;

  assign clock_state = phase;
  assign data_out    = acc;
  assign data_oe     = write | jmp;

  // Phase register: free-running T0->T1->T2->T3 ring
  always_ff @(posedge clk) begin
    if (rst) phase <= T0;
    else     phase <= phase_nxt;
  end

  // Phase successor
  always_comb begin
    phase_nxt = T0;
    case (phase)
      T0:      phase_nxt = T1;
      T1:      phase_nxt = T2;
      T2:      phase_nxt = T3;
      T3:      phase_nxt = T0;
      default: phase_nxt = T0;
    endcase
  end

  // Opcode fetch (end of T0) and operand capture (end of T2)
  always_ff @(posedge clk) begin
    if (rst) begin
      op   <= OP_LD;
      opnd <= 4'h0;
    end else begin
      if (phase == T0) op <= op_t'(instr);
      // An immediate is only taken by LD while i_f is set.
      if (phase == T2) opnd <= (op == OP_LD && i_f) ? instr : data_in;
    end
  end

  // Strobes: raised when the opcode is fetched and dropped when it commits.
  // While skip is set, the fetched opcode raises no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      write <= 1'b0;
      mar   <= 1'b0;
      jmp   <= 1'b0;
    end else if (phase == T0) begin
      write <= !skip && (instr == OP_STR);
      mar   <= !skip && (instr == OP_LML || instr == OP_LMH);
      jmp   <= !skip && (instr == OP_JMP);
    end else if (phase == T3) begin
      write <= 1'b0;
      mar   <= 1'b0;
      jmp   <= 1'b0;
    end
  end

  // Execute: compute the values committed at the end of T3
  always_comb begin
    acc_nxt   = acc;
    r_nxt     = r;
    db0_nxt   = db0;
    carry_nxt = carry;
    i_f_nxt   = i_f;
    skip_nxt  = skip;
    sum       = 5'd0;
    if (skip) begin
      // The skipped instruction is a NOP, and it consumes the skip.
      skip_nxt = 1'b0;
    end else begin
      case (op)
        OP_LD:   begin acc_nxt = opnd; i_f_nxt = 1'b0; end
        OP_STR:  ;
        OP_SEI:  i_f_nxt = 1'b1;
        OP_LML:  db0_nxt[3:0] = acc;
        OP_JMP:  db0_nxt = {r, acc};
        OP_SKF0: skip_nxt = ef0;
        OP_SKF1: skip_nxt = ef1;
        OP_LDR:  r_nxt = acc;
        OP_ADD:  begin
          sum = {1'b0, acc} + {1'b0, opnd};
          {carry_nxt, acc_nxt} = sum;
        end
        OP_SUB:  begin
          // carry=1 means no borrow
          sum = {1'b0, acc} + {1'b0, ~opnd} + 5'd1;
          {carry_nxt, acc_nxt} = sum;
        end
        OP_AND:  acc_nxt = acc & opnd;
        OP_OR:   acc_nxt = acc | opnd;
        OP_XOR:  acc_nxt = acc ^ opnd;
        OP_NOT:  acc_nxt = ~acc;
        OP_NOP:  ;
        OP_LMH:  db0_nxt[7:4] = acc;
        default: ;
      endcase
    end
  end

  // Architectural commit at the end of T3
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= 4'h0;
      r     <= 4'h0;
      db0   <= 8'h00;
      carry <= 1'b0;
      i_f   <= 1'b0;
      skip  <= 1'b0;
    end else if (phase == T3) begin
      acc   <= acc_nxt;
      r     <= r_nxt;
      db0   <= db0_nxt;
      carry <= carry_nxt;
      i_f   <= i_f_nxt;
      skip  <= skip_nxt;
    end
  end

endmodule

// File: tb/tb_as5401_cpu.sv
// Directed bench for as5401_cpu: one machine cycle per table row plus reset corner cases.
module tb_as5401_cpu;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] instr = 4'h0, data_in = 4'h0;
  logic       ef0 = 1'b0, ef1 = 1'b0;
  logic [3:0] data_out, clock_state;
  logic [7:0] db0;
  logic       data_oe, write, i_f, mar, jmp;

  int pass_cnt = 0;
  int total    = 0;

  as5401_cpu dut (
    .clk(clk), .rst(rst), .instr(instr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ef0(ef0), .ef1(ef1),
    .db0(db0), .clock_state(clock_state), .write(write), .i_f(i_f),
    .mar(mar), .jmp(jmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op, imm, din;
    logic       e0, e1;
    logic       w, m, j;
    logic [3:0] acc;
    logic [7:0] db0;
    logic       i_f;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [3:0] op, imm, din, input logic e0, e1,
                              input logic w, m, j, input logic [3:0] acc,
                              input logic [7:0] d, input logic f);
    vec_t v;
    v.op = op; v.imm = imm; v.din = din; v.e0 = e0; v.e1 = e1;
    v.w = w; v.m = m; v.j = j; v.acc = acc; v.db0 = d; v.i_f = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full machine cycle. It is entered in T0 and left in the next T0.
  task automatic run(input vec_t v, input int idx);
    logic [3:0] cs_exp;
    instr = v.op; data_in = v.din; ef0 = v.e0; ef1 = v.e1;
    chk($sformatf("t0_phase[%0d]", idx), clock_state, 4'b0001);
    chk($sformatf("t0_strobes[%0d]", idx), {write, mar, jmp, data_oe}, 4'b0000);
    step();
    instr = v.imm;
    cs_exp = 4'b0010;
    for (int p = 1; p <= 3; p++) begin
      chk($sformatf("phase[%0d]T%0d", idx, p), clock_state, cs_exp);
      chk($sformatf("strobes[%0d]T%0d", idx, p), {write, mar, jmp, data_oe},
          {v.w, v.m, v.j, v.w | v.j});
      cs_exp = cs_exp << 1;
      step();
    end
    chk($sformatf("data_out[%0d]", idx), data_out, v.acc);
    chk($sformatf("db0[%0d]", idx), db0, v.db0);
    chk($sformatf("i_f[%0d]", idx), i_f, v.i_f);
  endtask

  initial begin
    //            op    imm   din  e0 e1  w  m  j  acc   db0    i_f
    tv.push_back(mk(4'h2,4'h0,4'h0,0,0, 0,0,0, 4'h0,8'h00,1)); // SEI
    tv.push_back(mk(4'h0,4'h5,4'h0,0,0, 0,0,0, 4'h5,8'h00,0)); // LD #5
    tv.push_back(mk(4'h3,4'h0,4'h0,0,0, 0,1,0, 4'h5,8'h05,0)); // LML
    tv.push_back(mk(4'hF,4'h0,4'h0,0,0, 0,1,0, 4'h5,8'h55,0)); // LMH
    tv.push_back(mk(4'h8,4'h0,4'h3,0,0, 0,0,0, 4'h8,8'h55,0)); // ADD 3
    tv.push_back(mk(4'h1,4'h0,4'h0,0,0, 1,0,0, 4'h8,8'h55,0)); // STR
    tv.push_back(mk(4'h7,4'h0,4'h0,0,0, 0,0,0, 4'h8,8'h55,0)); // LDR
    tv.push_back(mk(4'h4,4'h0,4'h0,0,0, 0,0,1, 4'h8,8'h88,0)); // JMP
    tv.push_back(mk(4'h0,4'h2,4'hF,0,0, 0,0,0, 4'hF,8'h88,0)); // LD bus F
    tv.push_back(mk(4'h8,4'h0,4'h1,0,0, 0,0,0, 4'h0,8'h88,0)); // ADD wrap
    tv.push_back(mk(4'h9,4'h0,4'h3,0,0, 0,0,0, 4'hD,8'h88,0)); // SUB 0-3
    tv.push_back(mk(4'hA,4'h0,4'h6,0,0, 0,0,0, 4'h4,8'h88,0)); // AND
    tv.push_back(mk(4'hB,4'h0,4'h9,0,0, 0,0,0, 4'hD,8'h88,0)); // OR
    tv.push_back(mk(4'hC,4'h0,4'hF,0,0, 0,0,0, 4'h2,8'h88,0)); // XOR
    tv.push_back(mk(4'hD,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,0)); // NOT
    tv.push_back(mk(4'hE,4'h0,4'h5,0,0, 0,0,0, 4'hD,8'h88,0)); // NOP
    tv.push_back(mk(4'h5,4'h0,4'h0,1,0, 0,0,0, 4'hD,8'h88,0)); // SKF0 taken
    tv.push_back(mk(4'h1,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,0)); // STR skipped
    tv.push_back(mk(4'h5,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,0)); // SKF0 not taken
    tv.push_back(mk(4'h1,4'h0,4'h0,0,0, 1,0,0, 4'hD,8'h88,0)); // STR runs
    tv.push_back(mk(4'h6,4'h0,4'h0,0,1, 0,0,0, 4'hD,8'h88,0)); // SKF1 taken
    tv.push_back(mk(4'h2,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,0)); // SEI skipped
    tv.push_back(mk(4'h6,4'h0,4'h0,0,1, 0,0,0, 4'hD,8'h88,0)); // SKF1 taken
    tv.push_back(mk(4'h0,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,0)); // LD skipped
    tv.push_back(mk(4'h2,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,1)); // SEI
    tv.push_back(mk(4'hE,4'h0,4'h0,0,0, 0,0,0, 4'hD,8'h88,1)); // NOP, i_f held
    tv.push_back(mk(4'h0,4'hA,4'h3,0,0, 0,0,0, 4'hA,8'h88,0)); // LD #A
    tv.push_back(mk(4'h7,4'h0,4'h0,0,0, 0,0,0, 4'hA,8'h88,0)); // LDR
    tv.push_back(mk(4'h4,4'h0,4'h0,0,0, 0,0,1, 4'hA,8'hAA,0)); // JMP
    tv.push_back(mk(4'h5,4'h0,4'h0,1,0, 0,0,0, 4'hA,8'hAA,0)); // SKF0 taken
    tv.push_back(mk(4'h4,4'h0,4'h0,0,0, 0,0,0, 4'hA,8'hAA,0)); // JMP skipped

    // Reset state
    step(); step();
    chk("rst_phase", clock_state, 4'b0001);
    chk("rst_outs", {write, mar, jmp, data_oe, i_f}, 5'b0);
    chk("rst_data_out", data_out, 4'h0);
    chk("rst_db0", db0, 8'h00);
    rst = 1'b0;

    foreach (tv[i]) run(tv[i], i);

    // Reset during STR T2: no partial commit, strobe dropped, state cleared
    instr = 4'h1;
    step();
    chk("mid_write_T1", write, 1'b1);
    instr = 4'h0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_phase", clock_state, 4'b0001);
    chk("mid_rst_strobes", {write, mar, jmp, data_oe}, 4'b0000);
    chk("mid_rst_acc", data_out, 4'h0);
    chk("mid_rst_db0", db0, 8'h00);
    chk("mid_rst_i_f", i_f, 1'b0);
    rst = 1'b0;

    // Core resumes cleanly after reset
    run(mk(4'h0,4'h0,4'h7,0,0, 0,0,0, 4'h7,8'h00,0), 100);

    // ADD F+1 from a cleared state with a bus operand
    run(mk(4'h0,4'h0,4'hF,0,0, 0,0,0, 4'hF,8'h00,0), 101);
    run(mk(4'h8,4'h0,4'h1,0,0, 0,0,0, 4'h0,8'h00,0), 102);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
